// File: rtl/zigzag_input_framer.sv
// Input framer ahead of zigzag_decryption: buffers a byte stream in a FIFO and
// releases it frame by frame, holding off while the decryptor is busy.
module zigzag_input_framer #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 FIFO_DEPTH             = 64,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 BUSY_TIMEOUT           = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               busy_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic               valid_o,
  output logic               overflow_o,
  output logic               trunc_o,
  output logic [7:0]         frame_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d, wptr_vis_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;
  logic               trunc_q, trunc_d;
  logic [7:0]         frame_q, frame_d;
  logic               wr_en, empty, full_d;
  logic [D_WIDTH-1:0] rd_data;

  assign wr_en   = valid_i && ready_q;
  // Empty is judged against a one-cycle-old write pointer so a fresh byte
  // cannot be forwarded on the cycle right after it was written.
  assign empty   = (rptr_q == wptr_vis_q);
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  assign wptr_d     = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
  assign overflow_d = overflow_q | (valid_i & ~ready_q);
  assign full_d     = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  assign ready_d    = !full_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    data_d  = data_q;
    valid_d = 1'b0;
    trunc_d = trunc_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (!empty && !busy_i) state_d = SEND;
      end
      SEND: begin
        if (cnt_q == CW'(MAX_NOF_CHARS)) begin
          data_d  = START_DECRYPTION_TOKEN;
          valid_d = 1'b1;
          trunc_d = 1'b1;
          cnt_d   = '0;
          frame_d = frame_q + 8'd1;
          timer_d = '0;
          state_d = WAIT_HI;
        end else if (!empty) begin
          data_d  = rd_data;
          valid_d = 1'b1;
          rptr_d  = rptr_q + PTR_ONE;
          if (rd_data == START_DECRYPTION_TOKEN) begin
            cnt_d   = '0;
            frame_d = frame_q + 8'd1;
            timer_d = '0;
            state_d = WAIT_HI;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_HI: begin
        // A decryptor that received an empty frame never raises busy.
        if (busy_i) begin
          state_d = WAIT_LO;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      wptr_vis_q <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      trunc_q    <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      wptr_vis_q <= wptr_q;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      trunc_q    <= trunc_d;
      frame_q    <= frame_d;
    end
  end

  assign ready_o     = ready_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overflow_o  = overflow_q;
  assign trunc_o     = trunc_q;
  assign frame_cnt_o = frame_q;

endmodule
